gate_ctrl: RTL and testbench

GATE_CTRL -- requirements
Module: gate_ctrl

---
 rtl/gate_ctrl_if.sv | 27 ++
 rtl/gate_ctrl.sv | 146 ++++++++++++++
 tb/tb_gate_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_ctrl_if.sv
// Gate controller signal bundle: measurement control inputs, the counter-chain
// overflow input, and the counter-chain/status outputs.
// The master modport drives the i_* signals; the slave modport is the
// controller side.
interface gate_ctrl_if;
   logic        i_start;
   logic        i_abort;
   logic        i_cont;
   logic [15:0] i_gate_len;
   logic        i_ovf;
   logic        o_cnt_en;
   logic        o_cnt_clr_n;
   logic        o_latch;
   logic        o_busy;
   logic        o_done;
   logic        o_ovf_flag;

   modport master (
      output i_start, i_abort, i_cont, i_gate_len, i_ovf,
      input  o_cnt_en, o_cnt_clr_n, o_latch, o_busy, o_done, o_ovf_flag
   );

   modport slave (
      input  i_start, i_abort, i_cont, i_gate_len, i_ovf,
      output o_cnt_en, o_cnt_clr_n, o_latch, o_busy, o_done, o_ovf_flag
   );
endinterface

// File: rtl/gate_ctrl.sv
// Gate controller for an external decade-counter chain.
// Each measurement clears the chain, enables it for GATE_LEN cycles, and then
// strobes LATCH/DONE. If continuous mode is on, the next measurement starts
// with the same captured length.
// Build option: GATE_CTRL_HOLDOFF_EN inserts an 8-cycle HOLD between LATCH and
// CLEAR in continuous mode. This keeps the displayed value stable.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for START; BUSY low
// CLEAR | one cycle; counter chain cleared; overflow flag cleared
// GATE  | CNT_EN high; the gate counter decrements once per cycle
// LATCH | one cycle; LATCH/DONE strobe; CONT picks restart or IDLE
// HOLD  | (GATE_CTRL_HOLDOFF_EN only) 8-cycle pause before the next CLEAR
module gate_ctrl (
   input  logic          CLK,
   input  logic          RST,
   gate_ctrl_if.slave    bus
);

`ifdef GATE_CTRL_HOLDOFF_EN
   localparam logic [15:0] HOLD_LEN = 16'd8;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_GATE,
      S_LATCH
`ifdef GATE_CTRL_HOLDOFF_EN
      , S_HOLD
`endif
   } state_t;

   state_t      r_state;
   logic [15:0] r_len;
   logic [15:0] r_cnt;
   logic        r_cnt_en;
   logic        r_cnt_clr_n;
   logic        r_latch;
   logic        r_busy;
   logic        r_done;
   logic        r_ovf_flag;
   logic [15:0] w_len_eff;

   // A zero length still gives a one-cycle gate.
   assign w_len_eff = (bus.i_gate_len == 16'd0) ? 16'd1 : bus.i_gate_len;

   // Sequencer: state, gate counter and all registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state     <= S_IDLE;
         r_len       <= 16'd0;
         r_cnt       <= 16'd0;
         r_cnt_en    <= 1'b0;
         r_cnt_clr_n <= 1'b1;
         r_latch     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_ovf_flag  <= 1'b0;
      end else begin
         r_cnt_en    <= 1'b0;
         r_cnt_clr_n <= 1'b1;
         r_latch     <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b1;
         if ((r_state != S_IDLE) && bus.i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_busy <= 1'b0;
                  if (bus.i_start && !bus.i_abort) begin
                     r_state     <= S_CLEAR;
                     r_len       <= w_len_eff;
                     r_cnt       <= w_len_eff;
                     r_cnt_clr_n <= 1'b0;
                     r_ovf_flag  <= 1'b0;
                     r_busy      <= 1'b1;
                  end
               end
               S_CLEAR: begin
                  r_state  <= S_GATE;
                  r_cnt    <= r_len;
                  r_cnt_en <= 1'b1;
               end
               S_GATE: begin
                  if (bus.i_ovf) begin
                     r_ovf_flag <= 1'b1;
                  end
                  if (r_cnt <= 16'd1) begin
                     r_state <= S_LATCH;
                     r_cnt   <= 16'd0;
                     r_latch <= 1'b1;
                     r_done  <= 1'b1;
                  end else begin
                     r_cnt    <= r_cnt - 16'd1;
                     r_cnt_en <= 1'b1;
                  end
               end
               S_LATCH: begin
                  if (bus.i_cont) begin
`ifdef GATE_CTRL_HOLDOFF_EN
                     r_state <= S_HOLD;
                     r_cnt   <= HOLD_LEN;
`else
                     r_state     <= S_CLEAR;
                     r_cnt       <= r_len;
                     r_cnt_clr_n <= 1'b0;
                     r_ovf_flag  <= 1'b0;
`endif
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
`ifdef GATE_CTRL_HOLDOFF_EN
               S_HOLD: begin
                  if (r_cnt <= 16'd1) begin
                     r_state     <= S_CLEAR;
                     r_cnt       <= r_len;
                     r_cnt_clr_n <= 1'b0;
                     r_ovf_flag  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt - 16'd1;
                  end
               end
`endif
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.o_cnt_en    = r_cnt_en;
   assign bus.o_cnt_clr_n = r_cnt_clr_n;
   assign bus.o_latch     = r_latch;
   assign bus.o_busy      = r_busy;
   assign bus.o_done      = r_done;
   assign bus.o_ovf_flag  = r_ovf_flag;

endmodule

// File: tb/tb_gate_ctrl.sv
// Bench for gate_ctrl.
// The stimulus pushes one expected record per measurement into a queue.
// The monitor counts the CLEAR and CNT_EN cycles of each measurement.
// When a measurement ends, the monitor pops a record and checks it.
// A measurement ends on a DONE pulse, or when BUSY falls without DONE (abort or reset).
module tb_gate_ctrl;

   typedef struct {
      int en;
      int clr;
      int done;
      int ovf;
      int period;
   } exp_t;

   logic CLK;
   logic RST;
   int   total = 0;
   int   bad   = 0;
   exp_t q[$];

   gate_ctrl_if bus ();

   gate_ctrl dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

`ifdef GATE_CTRL_HOLDOFF_EN
   localparam int CONT_PERIOD = 14;
`else
   localparam int CONT_PERIOD = 6;
`endif

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endfunction

   function automatic void push(input int en, input int clr, input int done, input int ovf, input int period);
      exp_t e;
      e.en = en; e.clr = clr; e.done = done; e.ovf = ovf; e.period = period;
      q.push_back(e);
   endfunction

   // Monitor: accumulate per-measurement activity and score each end event
   initial begin
      int   en_c = 0;
      int   clr_c = 0;
      int   cyc = 0;
      int   last_done = 0;
      logic pb = 1'b0;
      logic pd = 1'b0;
      exp_t e;
      forever begin
         @(negedge CLK);
         cyc++;
         if (bus.o_cnt_en === 1'b1) en_c++;
         if (bus.o_cnt_clr_n === 1'b0) clr_c++;
         if (bus.o_done === 1'b1 || (pb && bus.o_busy === 1'b0 && !pd)) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_end: got done=%0d busy=%0d want no event", bus.o_done, bus.o_busy);
            end else begin
               e = q.pop_front();
               chk("end_done",  {31'd0, bus.o_done}, e.done);
               chk("end_latch", {31'd0, bus.o_latch}, e.done);
               chk("en_cycles", en_c, e.en);
               chk("clr_cycles", clr_c, e.clr);
               chk("ovf_flag_at_end", {31'd0, bus.o_ovf_flag}, e.ovf);
               if (e.period > 0) chk("cont_period", cyc - last_done, e.period);
            end
            if (bus.o_done === 1'b1) last_done = cyc;
            en_c  = 0;
            clr_c = 0;
         end
         pb = bus.o_busy;
         pd = bus.o_done;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_pulse(input logic [15:0] len);
      tick();
      bus.i_gate_len = len;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (bus.o_busy !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, bus.o_busy}, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cnt_en"},   {31'd0, bus.o_cnt_en}, 0);
      chk({tag, "_clr_n"},    {31'd0, bus.o_cnt_clr_n}, 1);
      chk({tag, "_latch"},    {31'd0, bus.o_latch}, 0);
      chk({tag, "_done"},     {31'd0, bus.o_done}, 0);
      chk({tag, "_busy"},     {31'd0, bus.o_busy}, 0);
      chk({tag, "_ovf_flag"}, {31'd0, bus.o_ovf_flag}, 0);
   endtask

   initial begin
      int n;
      int dones;
      int clrs;
      int done_at;
      int clr_at;

      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      bus.i_cont = 1'b0;
      bus.i_gate_len = 16'd0;
      bus.i_ovf = 1'b0;
      RST = 1'b1;
      #2 RST = 1'b0;
      #1 chk_reset_vals("rst");
      chk("rst_gate_cnt", {16'd0, dut.r_cnt}, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;

      // Basic measurement of length 5. The length input changes right after capture.
      push(5, 1, 1, 0, 0);
      start_pulse(16'd5);
      bus.i_gate_len = 16'd2;
      wait_idle(40, "len5_idle");

      // A zero length gives a one-cycle gate.
      push(1, 1, 1, 0, 0);
      start_pulse(16'd0);
      wait_idle(40, "len0_idle");

      // Overflow in GATE cycle 3 of 10. The flag stays set through IDLE and clears on the next CLEAR.
      push(10, 1, 1, 1, 0);
      start_pulse(16'd10);
      repeat (3) tick();
      bus.i_ovf = 1'b1;
      tick();
      bus.i_ovf = 1'b0;
      wait_idle(40, "ovf_idle");
      repeat (2) tick();
      chk("ovf_hold_idle", {31'd0, bus.o_ovf_flag}, 1);
      push(2, 1, 1, 0, 0);
      start_pulse(16'd2);
      chk("clear_clr_n", {31'd0, bus.o_cnt_clr_n}, 0);
      chk("clear_ovf_flag", {31'd0, bus.o_ovf_flag}, 0);
      chk("clear_busy", {31'd0, bus.o_busy}, 1);
      wait_idle(40, "ovf2_idle");

      // Continuous mode with length 4, three periods.
      bus.i_cont = 1'b1;
      push(4, 1, 1, 0, 0);
      push(4, 1, 1, 0, CONT_PERIOD);
      push(4, 1, 1, 0, CONT_PERIOD);
      start_pulse(16'd4);
      n = 0;
      dones = 0;
      while (dones < 3 && n < 200) begin
         tick();
         n++;
         if (bus.o_done === 1'b1) dones++;
      end
      bus.i_cont = 1'b0;
      chk("cont_dones", dones, 3);
      wait_idle(40, "cont_idle");

      // Abort in GATE cycle 2 of 8. An OVF seen in cycle 1 is kept.
      push(2, 1, 0, 1, 0);
      start_pulse(16'd8);
      tick();
      bus.i_ovf = 1'b1;
      tick();
      bus.i_ovf = 1'b0;
      bus.i_abort = 1'b1;
      tick();
      bus.i_abort = 1'b0;
      chk("abort_busy", {31'd0, bus.o_busy}, 0);
      chk("abort_cnt_en", {31'd0, bus.o_cnt_en}, 0);
      chk("abort_done", {31'd0, bus.o_done}, 0);

      // ABORT together with START in IDLE keeps the controller idle.
      bus.i_abort = 1'b1;
      bus.i_start = 1'b1;
      repeat (3) tick();
      chk("abort_start_idle", {31'd0, bus.o_busy}, 0);
      bus.i_abort = 1'b0;
      bus.i_start = 1'b0;
      tick();

      // START held high: the next measurement starts one cycle after the return to IDLE.
      push(2, 1, 1, 0, 0);
      push(2, 1, 1, 0, 0);
      bus.i_gate_len = 16'd2;
      bus.i_start = 1'b1;
      n = 0;
      clrs = 0;
      done_at = 0;
      clr_at = 0;
      while (clrs < 2 && n < 100) begin
         tick();
         n++;
         if (bus.o_done === 1'b1) done_at = n;
         if (bus.o_cnt_clr_n === 1'b0) begin
            clrs++;
            clr_at = n;
         end
      end
      bus.i_start = 1'b0;
      chk("restart_gap", clr_at - done_at, 2);
      wait_idle(40, "restart_idle");

      // Reset asserted between edges in the middle of GATE.
      push(1, 1, 0, 0, 0);
      start_pulse(16'd8);
      tick();
      tick();
      #2 RST = 1'b0;
      #1 chk_reset_vals("midrst");
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      repeat (4) tick();
      chk("post_rst_no_latch", {31'd0, bus.o_latch}, 0);
      push(3, 1, 1, 0, 0);
      start_pulse(16'd3);
      wait_idle(40, "post_rst_idle");

      repeat (3) tick();
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
